// File: rtl/cache_line_fill_engine.sv
// Line-fill engine: streams one cache line from a valid/ready memory read port into the victim way,
// then writes tag and fill state. Optional `CRITICAL_WORD_FIRST_EN starts the burst at requestOffset.
module cache_line_fill_engine #(
    parameter int TAG_WIDTH         = 6,
    parameter int INDEX_WIDTH       = 6,
    parameter int OFFSET_WIDTH      = 4,
    parameter int SET_ASSOCIATIVITY = 2,
    parameter int DATA_WIDTH        = 16,
    parameter int STATE_WIDTH       = 2,
    parameter logic [STATE_WIDTH-1:0] FILL_STATE = 2'b01
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        request,
    input  logic [TAG_WIDTH-1:0]                        requestTag,
    input  logic [INDEX_WIDTH-1:0]                      requestIndex,
    input  logic [OFFSET_WIDTH-1:0]                     requestOffset,
    input  logic [SET_ASSOCIATIVITY-1:0]                victimCacheNumber,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        memRead,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] memAddress,
    input  logic [DATA_WIDTH-1:0]                       memReadData,
    input  logic                                        memDataValid,
    output logic [SET_ASSOCIATIVITY-1:0]                cacheNumber,
    output logic                                        accessEnable,
    output logic [INDEX_WIDTH-1:0]                      cacheIndex,
    output logic [OFFSET_WIDTH-1:0]                     cacheOffset,
    output logic [DATA_WIDTH-1:0]                       cacheDataOut,
    output logic                                        cacheWriteData,
    output logic [TAG_WIDTH-1:0]                        cacheTagOut,
    output logic                                        cacheWriteTag,
    output logic [STATE_WIDTH-1:0]                      cacheStateOut,
    output logic                                        cacheWriteState
);

    localparam logic [SET_ASSOCIATIVITY-1:0] WAY_ZERO = SET_ASSOCIATIVITY'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TAG   = 2'd2,
        DONE  = 2'd3
    } fillState_t;

    fillState_t                   stateReg, stateNext;
    logic [TAG_WIDTH-1:0]         tagReg, tagNext;
    logic [INDEX_WIDTH-1:0]       indexReg, indexNext;
    logic [SET_ASSOCIATIVITY-1:0] wayReg, wayNext;
    logic [OFFSET_WIDTH-1:0]      offsetReg, offsetNext;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFFSET_WIDTH-1:0]      wordCountReg, wordCountNext;
`endif

    logic [OFFSET_WIDTH-1:0]      startOffset;
    logic                         lastWord;
    logic                         victimOneHot;
    logic [SET_ASSOCIATIVITY-1:0] acceptWay;

    // Prefix scan over the victim vector: seenOne = any bit so far, seenTwo = two or more bits so far.
    logic [SET_ASSOCIATIVITY:0] seenOne;
    logic [SET_ASSOCIATIVITY:0] seenTwo;

    assign seenOne[0] = 1'b0;
    assign seenTwo[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < SET_ASSOCIATIVITY; gi++) begin : gOneHot
            assign seenOne[gi+1] = seenOne[gi] | victimCacheNumber[gi];
            assign seenTwo[gi+1] = seenTwo[gi] | (seenOne[gi] & victimCacheNumber[gi]);
        end
    endgenerate

    assign victimOneHot = seenOne[SET_ASSOCIATIVITY] & ~seenTwo[SET_ASSOCIATIVITY];
    assign acceptWay    = victimOneHot ? victimCacheNumber : WAY_ZERO;

`ifdef CRITICAL_WORD_FIRST_EN
    assign startOffset = requestOffset;
    // Burst may wrap, so completion follows the word count rather than the offset.
    assign lastWord    = (wordCountReg == {OFFSET_WIDTH{1'b1}});
`else
    // The critical-word offset has no effect here; masking it keeps the port referenced.
    assign startOffset = requestOffset & {OFFSET_WIDTH{1'b0}};
    assign lastWord    = (offsetReg == {OFFSET_WIDTH{1'b1}});
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg     <= IDLE;
            tagReg       <= '0;
            indexReg     <= '0;
            wayReg       <= '0;
            offsetReg    <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            wordCountReg <= '0;
`endif
        end else begin
            stateReg     <= stateNext;
            tagReg       <= tagNext;
            indexReg     <= indexNext;
            wayReg       <= wayNext;
            offsetReg    <= offsetNext;
`ifdef CRITICAL_WORD_FIRST_EN
            wordCountReg <= wordCountNext;
`endif
        end
    end

    always_comb begin
        stateNext       = stateReg;
        tagNext         = tagReg;
        indexNext       = indexReg;
        wayNext         = wayReg;
        offsetNext      = offsetReg;
`ifdef CRITICAL_WORD_FIRST_EN
        wordCountNext   = wordCountReg;
`endif
        done            = 1'b0;
        memRead         = 1'b0;
        accessEnable    = 1'b0;
        cacheNumber     = '0;
        cacheWriteData  = 1'b0;
        cacheWriteTag   = 1'b0;
        cacheWriteState = 1'b0;
        cacheStateOut   = '0;

        case (stateReg)
            IDLE: begin
                if (request) begin
                    stateNext     = FETCH;
                    tagNext       = requestTag;
                    indexNext     = requestIndex;
                    wayNext       = acceptWay;
                    offsetNext    = startOffset;
`ifdef CRITICAL_WORD_FIRST_EN
                    wordCountNext = '0;
`endif
                end
            end
            FETCH: begin
                memRead        = 1'b1;
                accessEnable   = 1'b1;
                cacheNumber    = wayReg;
                cacheWriteData = memDataValid;
                if (memDataValid) begin
                    offsetNext    = offsetReg + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
                    wordCountNext = wordCountReg + 1'b1;
`endif
                    if (lastWord) begin
                        stateNext = TAG;
                    end
                end
            end
            TAG: begin
                accessEnable    = 1'b1;
                cacheNumber     = wayReg;
                cacheWriteTag   = 1'b1;
                cacheWriteState = 1'b1;
                cacheStateOut   = FILL_STATE;
                stateNext       = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy         = (stateReg != IDLE);
    assign memAddress   = {tagReg, indexReg, offsetReg};
    assign cacheIndex   = indexReg;
    assign cacheOffset  = offsetReg;
    assign cacheDataOut = memReadData;
    assign cacheTagOut  = tagReg;

endmodule
